// File: rtl/uart_rx_dma_ctrl_pkg.sv
// Shared encodings for the UART-RX DMA controller: config register map,
// control register bit positions and the channel FSM states.
package uart_rx_dma_ctrl_pkg;

  localparam logic [1:0] CFG_BASE   = 2'd0;
  localparam logic [1:0] CFG_LENGTH = 2'd1;
  localparam logic [1:0] CFG_CTRL   = 2'd2;
  localparam logic [1:0] CFG_THRESH = 2'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_CIRCULAR = 1;
  localparam int CTRL_CLEAR    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/uart_rx_dma_ctrl_byte_fifo.sv
// Small synchronous byte FIFO with a look-ahead head output. A push into a
// full FIFO is still accepted when a pop happens in the same cycle.
module uart_rx_dma_ctrl_byte_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_dma_ctrl.sv
// Shares the blockram port between the CPU data path and a UART-RX DMA channel
// that drains a byte FIFO into a linear or circular RAM buffer.
module uart_rx_dma_ctrl
  import uart_rx_dma_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [31:0] cfg_wdata,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [31:0] wr_count,
  output logic        irq,
  output logic        overflow
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [SW-1:0] sat_inc_starve(input logic [SW-1:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 1'b1;
  endfunction

  dma_state_e  state_q, state_d;
  logic [31:0] base_q, length_q, thresh_q, ptr_q;
  logic        enable_q, circular_q;
  logic [SW-1:0] starve_q;

  logic        fifo_full, fifo_empty, fifo_push;
  logic [7:0]  fifo_head;
  logic        cpu_req, cpu_gnt, dma_ok, dma_gnt;
  logic        last_byte, done_evt, thresh_evt, ovf_evt, clear_pulse;
  logic [31:0] abs_addr, wr_count_inc;

  assign cpu_rdata    = ram_rdata;
  assign cpu_req      = cpu_read || cpu_write;
  assign dma_ok       = !fifo_empty && (state_q == ST_RUN);
  assign fifo_push    = rx_valid && (state_q == ST_RUN);
  assign abs_addr     = base_q + ptr_q;
  assign last_byte    = (ptr_q == length_q - 32'd1);
  assign wr_count_inc = sat_inc32(wr_count);
  assign done_evt     = dma_gnt && last_byte && !circular_q;
  assign thresh_evt   = dma_gnt && (thresh_q != '0) && (wr_count_inc != wr_count)
                        && (wr_count_inc == thresh_q);
  assign ovf_evt      = rx_valid && (((state_q == ST_RUN) && fifo_full && !dma_gnt)
                                     || (state_q == ST_DONE));
  assign clear_pulse  = cfg_we && (cfg_sel == CFG_CTRL) && cfg_wdata[CTRL_CLEAR];

  uart_rx_dma_ctrl_byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_byte_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (state_q == ST_ARM),
    .push      (fifo_push),
    .pop       (dma_gnt),
    .push_data (rx_data),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // CPU wins unless the DMA has been starved long enough; port muxed combinationally.
  always_comb begin
    cpu_gnt   = cpu_req && ((starve_q < STARVE_LIM) || fifo_empty);
    dma_gnt   = !cpu_gnt && dma_ok;
    cpu_stall = cpu_req && !cpu_gnt;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_we    = cpu_write;
      ram_be    = cpu_be;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      ram_we    = 1'b1;
      ram_be    = 4'b0001 << abs_addr[1:0];
      ram_addr  = {abs_addr[31:2], 2'b00};
      ram_wdata = {4{fifo_head}};
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (length_q != '0) state_d = ST_ARM;
        ST_ARM:  state_d = ST_RUN;
        ST_RUN:  if (done_evt) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      length_q   <= '0;
      thresh_q   <= '0;
      enable_q   <= 1'b0;
      circular_q <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_sel)
        CFG_BASE:   if (state_q == ST_IDLE) base_q <= cfg_wdata;
        CFG_LENGTH: if (state_q == ST_IDLE) length_q <= cfg_wdata;
        CFG_CTRL: begin
          enable_q   <= cfg_wdata[CTRL_ENABLE];
          circular_q <= cfg_wdata[CTRL_CIRCULAR];
        end
        default:    thresh_q <= cfg_wdata;
      endcase
    end
  end

  // Status set events take priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      starve_q <= '0;
      wr_count <= '0;
      irq      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ARM) begin
        ptr_q    <= '0;
        wr_count <= '0;
      end else if (dma_gnt) begin
        ptr_q    <= last_byte ? '0 : ptr_q + 32'd1;
        wr_count <= wr_count_inc;
      end
      if (!dma_ok || dma_gnt) starve_q <= '0;
      else                    starve_q <= sat_inc_starve(starve_q);
      irq      <= (irq && !clear_pulse) || done_evt || thresh_evt;
      overflow <= (overflow && !clear_pulse) || ovf_evt;
    end
  end

endmodule

// File: tb/tb_uart_rx_dma_ctrl.sv
// Bench for uart_rx_dma_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_uart_rx_dma_ctrl;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;

  logic        clk;
  logic        reset_n;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        cpu_read, cpu_write, cpu_stall;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [31:0] wr_count;
  logic        irq, overflow;

  uart_rx_dma_ctrl #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_count(wr_count), .irq(irq), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int          m_state, m_starve;
  logic [31:0] m_base, m_len, m_thr, m_ptr, m_cnt;
  bit          m_en, m_circ, m_irq, m_ovf;
  logic [7:0]  m_q[$];
  bit          e_cpu, e_dma, e_we, e_stall;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [7:0] dat; } wr_t;
  wr_t         wlog[$];
  logic        o_stall;
  logic [31:0] o_addr;

  function automatic void model_reset();
    m_state = M_IDLE; m_starve = 0;
    m_base = 0; m_len = 0; m_thr = 0; m_ptr = 0; m_cnt = 0;
    m_en = 0; m_circ = 0; m_irq = 0; m_ovf = 0;
    m_q.delete();
  endfunction

  function automatic void model_comb();
    bit req, has;
    logic [31:0] a;
    req     = cpu_read || cpu_write;
    has     = (m_q.size() != 0);
    e_cpu   = req && (m_starve < SMAX || !has);
    e_dma   = !e_cpu && has && (m_state == M_RUN);
    e_stall = req && !e_cpu;
    e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
    if (e_cpu) begin
      e_we = cpu_write; e_be = cpu_be; e_addr = cpu_addr; e_wdata = cpu_wdata;
    end else if (e_dma) begin
      a       = m_base + m_ptr;
      e_we    = 1;
      e_be    = 4'(1 << a[1:0]);
      e_addr  = a & 32'hFFFF_FFFC;
      e_wdata = {4{m_q[0]}};
    end
  endfunction

  function automatic void model_edge();
    bit clr, set_irq, set_ovf, finished, had;
    int nxt;
    clr = cfg_we && (cfg_sel == 2'd2) && cfg_wdata[2];
    had = (m_q.size() != 0);
    set_irq = 0; set_ovf = 0; finished = 0;
    if (e_dma) begin
      m_q.delete(0);
      if (m_cnt != 32'hFFFF_FFFF) begin
        m_cnt = m_cnt + 1;
        if (m_thr != 0 && m_cnt == m_thr) set_irq = 1;
      end
      if (m_ptr == m_len - 1) begin
        m_ptr = 0;
        if (!m_circ) finished = 1;
      end else m_ptr = m_ptr + 1;
    end
    if (finished) set_irq = 1;
    if (rx_valid && m_state == M_RUN) begin
      if (m_q.size() < DEPTH) m_q.push_back(rx_data);
      else set_ovf = 1;
    end
    if (rx_valid && m_state == M_DONE) set_ovf = 1;
    if (m_state == M_RUN && had && !e_dma) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    else m_starve = 0;
    nxt = m_state;
    if (!m_en) nxt = M_IDLE;
    else if (m_state == M_IDLE && m_len != 0) nxt = M_ARM;
    else if (m_state == M_ARM) nxt = M_RUN;
    else if (m_state == M_RUN && finished) nxt = M_DONE;
    if (m_state == M_ARM) begin
      m_q.delete(); m_ptr = 0; m_cnt = 0;
    end
    m_irq = (m_irq && !clr) || set_irq;
    m_ovf = (m_ovf && !clr) || set_ovf;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: if (m_state == M_IDLE) m_base = cfg_wdata;
        2'd1: if (m_state == M_IDLE) m_len = cfg_wdata;
        2'd2: begin m_en = cfg_wdata[0]; m_circ = cfg_wdata[1]; end
        default: m_thr = cfg_wdata;
      endcase
    end
    m_state = nxt;
  endfunction

  task automatic set_idle();
    cpu_addr = 0; cpu_wdata = 0; cpu_be = 0; cpu_read = 0; cpu_write = 0;
    rx_valid = 0; rx_data = 0; cfg_we = 0; cfg_sel = 0; cfg_wdata = 0;
  endtask

  // One clock cycle: inputs are set at the falling edge before calling.
  task automatic tick();
    ram_rdata = $urandom;
    #1;
    model_comb();
    chk_val("ram_we", 32'(ram_we), 32'(e_we));
    chk_val("ram_be", 32'(ram_be), 32'(e_be));
    chk_val("ram_addr", ram_addr, e_addr);
    chk_val("ram_wdata", ram_wdata, e_wdata);
    chk_val("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk_val("cpu_rdata", cpu_rdata, ram_rdata);
    o_stall = cpu_stall;
    o_addr  = ram_addr;
    if (ram_we && (!(cpu_read || cpu_write) || cpu_stall))
      wlog.push_back('{addr: ram_addr, be: ram_be, dat: ram_wdata[7:0]});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_val("wr_count", wr_count, m_cnt);
    chk_val("irq", 32'(irq), 32'(m_irq));
    chk_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1; rx_data = b;
    tick();
    rx_valid = 0;
  endtask

  task automatic disable_dma(input logic [31:0] ctrl);
    cfg_write(2'd2, ctrl);
    idle(1);
  endtask

  task automatic chk_log(input int idx, input logic [31:0] addr, input logic [3:0] be);
    chk_val($sformatf("wlog%0d_addr", idx), wlog[idx].addr, addr);
    chk_val($sformatf("wlog%0d_be", idx), 32'(wlog[idx].be), 32'(be));
  endtask

  initial begin
    int stall_n, stall_at;
    bit circ;
    reset_n = 0;
    ram_rdata = 0;
    set_idle();
    model_reset();
    #1;
    chk_val("rst_ram_we", 32'(ram_we), 0);
    chk_val("rst_ram_addr", ram_addr, 0);
    chk_val("rst_wr_count", wr_count, 0);
    chk_val("rst_irq", 32'(irq), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;

    // Linear fill
    cfg_write(2'd0, 32'h100); cfg_write(2'd1, 3); cfg_write(2'd2, 1);
    idle(2);
    wlog.delete();
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    idle(2);
    chk_val("lin_nwr", wlog.size(), 3);
    if (wlog.size() >= 3) begin
      chk_log(0, 32'h100, 4'b0001); chk_log(1, 32'h100, 4'b0010); chk_log(2, 32'h100, 4'b0100);
      chk_val("lin_dat2", 32'(wlog[2].dat), 32'hC3);
    end
    chk_val("lin_cnt", wr_count, 3);
    chk_val("lin_irq", 32'(irq), 1);
    send_byte(8'hD4);
    idle(1);
    chk_val("lin_ovf", 32'(overflow), 1);
    disable_dma(32'h4);
    chk_val("clr_irq", 32'(irq), 0);
    chk_val("clr_ovf", 32'(overflow), 0);

    // Circular wrap
    cfg_write(2'd0, 32'h203); cfg_write(2'd1, 2); cfg_write(2'd2, 3);
    idle(2);
    wlog.delete();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(2);
    chk_val("circ_nwr", wlog.size(), 3);
    if (wlog.size() >= 3) begin
      chk_log(0, 32'h200, 4'b1000); chk_log(1, 32'h204, 4'b0001); chk_log(2, 32'h200, 4'b1000);
    end
    chk_val("circ_cnt", wr_count, 3);
    disable_dma(32'h4);

    // Threshold and base lockout
    cfg_write(2'd0, 32'h400); cfg_write(2'd1, 8); cfg_write(2'd3, 2); cfg_write(2'd2, 1);
    idle(2);
    send_byte(8'h11); idle(1);
    chk_val("thr_irq1", 32'(irq), 0);
    send_byte(8'h22); idle(1);
    chk_val("thr_irq2", 32'(irq), 1);
    cfg_write(2'd0, 32'h800);
    wlog.delete();
    send_byte(8'h33); idle(1);
    chk_val("lock_nwr", wlog.size(), 1);
    if (wlog.size() >= 1) chk_log(0, 32'h400, 4'b0100);
    disable_dma(32'h4);

    // Starvation under continuous CPU reads
    cfg_write(2'd0, 32'h300); cfg_write(2'd1, 16); cfg_write(2'd3, 0); cfg_write(2'd2, 1);
    idle(2);
    cpu_read = 1; cpu_addr = 32'h1230; cpu_be = 4'hF;
    send_byte(8'h5A);
    stall_n = 0; stall_at = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (stall_at != 0 && k == stall_at + 1) chk_val("stall_replay_addr", o_addr, 32'h1230);
      if (o_stall) begin
        stall_n++;
        if (stall_at == 0) stall_at = k;
      end
    end
    chk_val("stall_count", stall_n, 1);
    chk_val("stall_cycle", stall_at, 9);

    // FIFO overflow under continuous CPU writes
    cpu_read = 0; cpu_write = 1; cpu_wdata = $urandom;
    wlog.delete();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
    chk_val("fifo_ovf", 32'(overflow), 1);
    cfg_write(2'd2, 32'h5);
    chk_val("fifo_ovf_clr", 32'(overflow), 0);
    cpu_write = 0;
    idle(5);
    chk_val("fifo_nwr", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) chk_val($sformatf("fifo_dat%0d", i), 32'(wlog[i].dat), 32'(8'h10 + i));

    // Reset with bytes queued
    cpu_read = 1; cpu_addr = 32'h40;
    send_byte(8'h77); send_byte(8'h78);
    reset_n = 0;
    set_idle();
    #1;
    chk_val("mid_ram_we", 32'(ram_we), 0);
    chk_val("mid_ram_be", 32'(ram_be), 0);
    chk_val("mid_ram_addr", ram_addr, 0);
    chk_val("mid_ram_wdata", ram_wdata, 0);
    chk_val("mid_stall", 32'(cpu_stall), 0);
    chk_val("mid_wr_count", wr_count, 0);
    chk_val("mid_irq", 32'(irq), 0);
    chk_val("mid_ovf", 32'(overflow), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    wlog.delete();
    idle(6);
    chk_val("mid_nwr", wlog.size(), 0);

    // Randomized traffic
    for (int r = 0; r < 10; r++) begin
      disable_dma(32'h4);
      circ = 1'($urandom_range(0, 1));
      cfg_write(2'd0, $urandom);
      cfg_write(2'd1, $urandom_range(0, 6));
      cfg_write(2'd3, $urandom_range(0, 5));
      cfg_write(2'd2, {30'd0, circ, 1'b1});
      for (int c = 0; c < 150; c++) begin
        case ($urandom_range(0, 3))
          0: begin cpu_read = 1; cpu_write = 0; end
          1: begin cpu_read = 0; cpu_write = 1; end
          default: begin cpu_read = 0; cpu_write = 0; end
        endcase
        cpu_addr = $urandom; cpu_wdata = $urandom; cpu_be = 4'($urandom);
        rx_valid = ($urandom_range(0, 2) == 0);
        rx_data = 8'($urandom);
        cfg_we = ($urandom_range(0, 24) == 0);
        cfg_sel = 2'($urandom);
        cfg_wdata = $urandom;
        cfg_wdata[0] = ($urandom_range(0, 9) != 0);
        tick();
      end
      set_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
